// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package serial_adder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_WIDTH = 32;

  // Counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between the tile pins and the serial adder.
// Handshake: start is sampled on a rising edge only while busy=0; done pulses for one
// cycle when sum/cout/ovf update; a start presented during the done cycle is accepted.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;
  logic [0:0]       state;

  modport master (
    output start, sub, cin, a, b,
    input  sum, cout, ovf, busy, done, state
  );

  modport slave (
    input  start, sub, cin, a, b,
    output sum, cout, ovf, busy, done, state
  );
endinterface

// File: rtl/serial_adder_core_full_adder_cell.sv
// Single combinational full-adder cell, reused every cycle by the serial datapath.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

// File: rtl/serial_adder_core.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell iterated LSB-first over WIDTH cycles.
module serial_adder_core
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [0:0]       S_IDLE   = 1'(IDLE);
  localparam logic [0:0]       S_RUN    = 1'(RUN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] res_shift;

  full_adder_cell u_fa (
    .a_i  (sha_q[0]),
    .b_i  (shb_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // New bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  assign res_shift = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          sha_d   = bus.a;
          shb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        carry_d = fa_co;
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        // On the last bit carry_q is exactly the carry into the MSB.
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
          sum_d   = res_shift;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.state = state_q;

endmodule

// File: doc/serial_adder_core.md
Name: serial_adder_core

Overview:
- Parametrised bit-serial add/subtract engine; the multi-bit, sequential successor to the team's single-bit half-adder tile.
- Adds or subtracts two WIDTH-bit operands using one full-adder cell, iterated LSB-first over WIDTH cycles.
- Uses a start/busy/done handshake.
- Sits behind the tile's input pins as the arithmetic datapath; the top-level wrapper maps ui_in/uio_in onto its operands.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1, cin ignored); captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add mode; captured with start.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  final carry; in sub mode 1 = no borrow (a>=b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum/cout/ovf update.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. While rst=1:
  - state=IDLE
  - sum=0, cout=0, ovf=0, busy=0, done=0
  - internal shift registers, carry and counter are cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN on the edge where start=1:
  - load shA=a.
  - load shB = sub ? ~b : b.
  - load carry = sub ? 1 : cin.
  - cnt=0; busy goes 1 after this edge.
- Each RUN edge:
  - bit s = shA[0]^shB[0]^carry; carry_next = majority(shA[0], shB[0], carry).
  - shA and shB shift right by one.
  - s shifts into the MSB of the result shift register.
  - cnt increments.
  - The carry into the MSB is remembered on the edge where cnt==WIDTH-1.
- RUN -> IDLE on the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge). On that same edge:
  - sum <= completed shift register.
  - cout <= carry_next.
  - ovf <= carry_into_msb ^ carry_next.
  - done <= 1; busy <= 0.
- done is registered and lasts exactly one cycle.
- Latency: start sampled at edge k gives done=1 and valid results in the cycle after edge k+WIDTH.
- Throughput: one operation per WIDTH+1 cycles.
- start while busy=1 is ignored; no queuing, no error flag. Operand changes during RUN have no effect.
- start=1 during the done cycle (busy=0) is accepted: back-to-back operation, done deasserts next cycle.
- WIDTH=1: a single RUN edge; the result equals a one-bit full adder. With cin=0 it matches the half-adder tile (sum=a^b, cout=a&b).
- Wrap-around: sum is modulo 2^WIDTH; carry-out is reported only via cout.
- Reset mid-RUN: aborts immediately and all outputs clear. The next start after rst deasserts runs normally.
- sum/cout/ovf retain the last completed result while IDLE and throughout a following RUN; they change only on done edges or reset.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum {IDLE, RUN}.
  - localparam for the maximum supported WIDTH (32).
  - a helper function for CNT_W.
- One natural sub-module: full_adder_cell, combinational (a, b, ci -> s, co); instantiated once in the datapath.
- No other hierarchy.

Test Plan (WIDTH=8 unless noted):
- a=0x5A, b=0x3C, sub=0, cin=0, start pulse -> done exactly 9 cycles after start edge; sum=0x96, cout=0, ovf=1; busy high for 8 cycles.
- a=0xFF, b=0x01, sub=0, cin=1 -> sum=0x01, cout=1, ovf=0; then a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow), ovf=0.
- a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1. A start issued in the done cycle with a=0x01, b=0x01, sub=0 is accepted -> next done gives sum=0x02.
- Start a=0x11, b=0x22; at cycle 3 pulse start with a=0xFF, b=0xFF and change the a/b pins -> ignored; result sum=0x33, exactly one done pulse.
- Assert rst asynchronously (mid-cycle) 4 cycles into RUN -> busy/done/sum/cout/ovf read 0 immediately. After release, start a=0x03, b=0x04 -> sum=0x07 after 9 cycles.
- WIDTH=1 instance, sub=0, cin=0, all four (a,b) combinations -> (sum,cout) = (0,0), (1,0), (1,0), (0,1); done 2 cycles after each start.
